// File: rtl/disp_share_arbiter_pkg.sv
// disp_pkg: shared types for the display-share arbiter.
// Holds the FSM state enum, digit count and hold-counter width.
package disp_pkg;

  localparam int DIGITS = 4;
  localparam int CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OWN
  } arb_state_t;

endpackage

// File: rtl/disp_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin one-hot picker.
// Ports: req, last (previous owner) -> win (one-hot), win_idx.
module rr_pick
  import disp_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [PW-1:0]   win_idx
);

  logic [PW-1:0] j;

  // Walk from farthest to nearest so the
  // nearest requester after last wins.
  always_comb begin
    win     = '0;
    win_idx = '0;
    j       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      j = PW'((int'(last) + k) % NREQ);
      if (req[j]) begin
        win     = '0;
        win[j]  = 1'b1;
        win_idx = j;
      end
    end
  end

endmodule

// File: rtl/disp_share_arbiter.sv
// disp_share_arbiter: round-robin owner of the 4-digit display.
// Ports: clk, reset, req, value_in, dp_mask_in -> gnt, hex3..hex0,
// dp_out, busy. Macro DISP_ARB_TIMEOUT_EN enables preemption.
module disp_share_arbiter
  import disp_pkg::*;
#(
  parameter int          NREQ       = 4,
  parameter int          MIN_HOLD   = 12000000,
  parameter int          MAX_HOLD   = 48000000,
  parameter logic [15:0] IDLE_VALUE = 16'h0000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  value_in,
  input  logic [4*NREQ-1:0]   dp_mask_in,
  output logic [NREQ-1:0]     gnt,
  output logic [3:0]          hex3,
  output logic [3:0]          hex2,
  output logic [3:0]          hex1,
  output logic [3:0]          hex0,
  output logic [DIGITS-1:0]   dp_out,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_HOLD - 1);
`ifdef DISP_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] SAT = CNT_W'(MAX_HOLD - 1);
`else
  localparam logic [CNT_W-1:0] SAT = MIN_LAST;
`endif

  if (NREQ < 2 || NREQ > 4 || MIN_HOLD < 1 ||
      MAX_HOLD <= MIN_HOLD) begin : g_bad_cfg
    $error("disp_share_arbiter: illegal parameters");
  end

  arb_state_t       state, state_d;
  logic [CNT_W-1:0] hold_cnt, cnt_d, cnt_inc;
  logic [NREQ-1:0]  gnt_d, win;
  logic [PW-1:0]    own_idx, idx_d, win_idx;
  logic [PW-1:0]    ptr, ptr_d;
  logic [15:0]      disp_q;
  logic [3:0]       dp_q;
  logic             preempt;
  logic [15:0]      vals [NREQ];
  logic [3:0]       dps  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign vals[i] = value_in[16*i +: 16];
    assign dps[i]  = dp_mask_in[4*i +: 4];
  end

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req     (req),
    .last    (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

`ifdef DISP_ARB_TIMEOUT_EN
  // Only a waiting contender can take the display away.
  assign preempt = (hold_cnt == SAT) && |(req & ~gnt);
`else
  assign preempt = 1'b0;
`endif

  assign cnt_inc = (hold_cnt == SAT) ? hold_cnt
                                     : hold_cnt + CNT_W'(1);

  always_comb begin
    state_d = state;
    cnt_d   = hold_cnt;
    gnt_d   = gnt;
    idx_d   = own_idx;
    ptr_d   = ptr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          idx_d   = win_idx;
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_inc;
        if (hold_cnt == MIN_LAST) state_d = OWN;
      end
      OWN: begin
        cnt_d = cnt_inc;
        if (!req[own_idx] || preempt) begin
          gnt_d   = '0;
          ptr_d   = own_idx;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gnt      <= '0;
      own_idx  <= '0;
      ptr      <= PW'(NREQ - 1);
    end else begin
      state    <= state_d;
      hold_cnt <= cnt_d;
      gnt      <= gnt_d;
      own_idx  <= idx_d;
      ptr      <= ptr_d;
    end
  end

  // Owner data is tracked live, one edge behind gnt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_q <= IDLE_VALUE;
      dp_q   <= '0;
    end else if (|gnt) begin
      disp_q <= vals[own_idx];
      dp_q   <= dps[own_idx];
    end else begin
      disp_q <= IDLE_VALUE;
      dp_q   <= '0;
    end
  end

  assign hex3   = disp_q[15:12];
  assign hex2   = disp_q[11:8];
  assign hex1   = disp_q[7:4];
  assign hex0   = disp_q[3:0];
  assign dp_out = dp_q;
  assign busy   = |gnt;

endmodule

// File: tb/tb_disp_share_arbiter.sv
// tb_disp_share_arbiter: scoreboard bench for disp_share_arbiter.
// Runs with MIN_HOLD=4, MAX_HOLD=10, NREQ=4.
module tb_disp_share_arbiter;

  localparam int NREQ     = 4;
  localparam int MIN_HOLD = 4;
  localparam int MAX_HOLD = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] val [4];
  logic [3:0]  dpm [4];
  logic [63:0] value_in;
  logic [15:0] dp_mask_in;
  logic [3:0]  gnt;
  logic [3:0]  hex3, hex2, hex1, hex0;
  logic [3:0]  dp_out;
  logic        busy;

  typedef struct {
    string       tag;
    logic [3:0]  gnt;
    logic [19:0] disp;
  } exp_t;

  exp_t       sb[$];
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] prev_g = '0;

  assign value_in   = {val[3], val[2], val[1], val[0]};
  assign dp_mask_in = {dpm[3], dpm[2], dpm[1], dpm[0]};

  always #5 clk = ~clk;

  disp_share_arbiter #(
    .NREQ       (NREQ),
    .MIN_HOLD   (MIN_HOLD),
    .MAX_HOLD   (MAX_HOLD),
    .IDLE_VALUE (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .value_in   (value_in),
    .dp_mask_in (dp_mask_in),
    .gnt        (gnt),
    .hex3       (hex3),
    .hex2       (hex2),
    .hex1       (hex1),
    .hex0       (hex0),
    .dp_out     (dp_out),
    .busy       (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [19:0] disp_of(input logic [3:0] g);
    logic [19:0] d;
    d = {16'h0000, 4'b0000};
    for (int i = 0; i < 4; i++)
      if (g[i]) d = {val[i], dpm[i]};
    return d;
  endfunction

  function automatic logic [19:0] disp_now();
    return {hex3, hex2, hex1, hex0, dp_out};
  endfunction

  task automatic step(input logic [3:0] r,
                      input logic [3:0] g,
                      input string tag);
    exp_t e;
    req    = r;
    e.tag  = tag;
    e.gnt  = g;
    e.disp = disp_of(prev_g);
    sb.push_back(e);
    prev_g = g;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.tag, "_gnt"}, 32'(gnt), 32'(e.gnt));
    check({e.tag, "_busy"}, 32'(busy), 32'(|e.gnt));
    check({e.tag, "_disp"}, 32'(disp_now()), 32'(e.disp));
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_disp", 32'(disp_now()), 32'h0);
    reset  = 1'b0;
    prev_g = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    val[0] = 16'h1234; dpm[0] = 4'b0100;
    val[1] = 16'h5678; dpm[1] = 4'b0001;
    val[2] = 16'h9abc; dpm[2] = 4'b1000;
    val[3] = 16'hdef0; dpm[3] = 4'b0010;

    // grant, data one edge later, live data, drop in HOLD
    do_reset();
    step(4'b0001, 4'b0001, "s1_grant");
    step(4'b0001, 4'b0001, "s1_data");
    val[0] = 16'habcd;
    step(4'b0001, 4'b0001, "s2_live");
    step(4'b0000, 4'b0001, "s2_hold");
    step(4'b0000, 4'b0001, "s2_hold");
    step(4'b0000, 4'b0000, "s2_rel");
    step(4'b0000, 4'b0000, "s2_idle");
    val[0] = 16'h1234;

    // all request; each drops on its first OWN cycle
    do_reset();
    for (int o = 0; o < 4; o++) begin
      for (int k = 0; k < 5; k++)
        step(4'b1111, 4'(1 << o), "s3_own");
      step(4'b1111 & ~4'(1 << o), 4'b0000, "s3_gap");
    end
    step(4'b1111, 4'b0001, "s3_wrap");

    // owner never drops; req2 contends from cycle 3
    do_reset();
`ifdef DISP_ARB_TIMEOUT_EN
    for (int k = 0; k < 10; k++)
      step(k < 3 ? 4'b0001 : 4'b0101, 4'b0001, "s4_own");
    step(4'b0101, 4'b0000, "s4_gap");
    step(4'b0101, 4'b0100, "s4_next");
`else
    for (int k = 0; k < 50; k++)
      step(k < 3 ? 4'b0001 : 4'b0101, 4'b0001, "s5_keep");
`endif

    // async reset mid-grant, then fresh pointer
    do_reset();
    step(4'b0100, 4'b0100, "s6_own");
    step(4'b0100, 4'b0100, "s6_data");
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_gnt", 32'(gnt), 32'h0);
    check("s6_async_busy", 32'(busy), 32'h0);
    check("s6_async_disp", 32'(disp_now()), 32'h0);
    req    = '0;
    reset  = 1'b0;
    prev_g = '0;
    step(4'b0110, 4'b0010, "s6_regrant");
    step(4'b0110, 4'b0010, "s6_data1");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
